// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle MIPS divider.
// Holds the width, FSM encodings, special result values and the per-operation flag bundle.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [DIV_WIDTH-1:0] INT_MIN    = 32'h8000_0000;

    typedef struct packed {
        logic a_neg;
        logic b_neg;
        logic div_zero;
        logic overflow;
    } div_flags_t;

endpackage

// File: rtl/sequential_divide_if.sv
// Operand/result handshake between the HI/LO control logic (master) and the divider (slave).
interface sequential_divide_if import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             do_div;
    logic             is_signed;
    logic             busy;
    logic             value_ready;
    logic             exception;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output A, B, do_div, is_signed,
        input  busy, value_ready, exception, quotient, remainder
    );

    modport slave (
        input  A, B, do_div, is_signed,
        output busy, value_ready, exception, quotient, remainder
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left by one, trial-subtract the divisor from the
// WIDTH+1-bit shifted remainder, keep the difference when it is non-negative and shift in that q-bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The stored remainder is always below the divisor, so its shifted form fits in WIDTH+1 bits.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor_i};

    assign rem_o = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/sequential_divide.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock behind a start/ready/exception handshake.
// Define DIV_SIGNED_EN to honour is_signed (two's-complement operands, sign fix-up, overflow detection).
module sequential_divide import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic                clk,
    input logic                reset_n,
    sequential_divide_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [1:0]       state_q,       state_d;
    logic [CNT_W-1:0] count_q,       count_d;
    logic [WIDTH-1:0] rem_q,         rem_d;
    logic [WIDTH-1:0] quo_q,         quo_d;
    logic [WIDTH-1:0] divisor_q,     divisor_d;
    div_flags_t       flags_q,       flags_d;
    logic [WIDTH-1:0] quotient_q,    quotient_d;
    logic [WIDTH-1:0] remainder_q,   remainder_d;
    logic             value_ready_q, value_ready_d;
    logic             exception_q,   exception_d;

    logic             signed_op;
    div_flags_t       start_flags;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;

`ifdef DIV_SIGNED_EN
    assign signed_op = bus.is_signed;
`else
    logic unused_is_signed;
    assign unused_is_signed = bus.is_signed;
    assign signed_op        = 1'b0;
`endif

    always_comb begin
        start_flags.a_neg    = signed_op & bus.A[WIDTH-1];
        start_flags.b_neg    = signed_op & bus.B[WIDTH-1];
        start_flags.div_zero = (bus.B == '0);
        start_flags.overflow = signed_op && (bus.A == INT_MIN) && (bus.B == '1);
    end

    assign a_abs = start_flags.a_neg ? -bus.A : bus.A;
    assign b_abs = start_flags.b_neg ? -bus.B : bus.B;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through the case can infer a latch.
        state_d       = state_q;
        count_d       = count_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        divisor_d     = divisor_q;
        flags_d       = flags_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        value_ready_d = 1'b0;
        exception_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.do_div) begin
                    state_d   = ST_BUSY;
                    count_d   = CNT_W'(WIDTH);
                    rem_d     = '0;
                    quo_d     = a_abs;
                    divisor_d = b_abs;
                    flags_d   = start_flags;
                end
            end
            ST_BUSY: begin
                if (flags_q.div_zero) begin
                    state_d = ST_DONE;
                    count_d = '0;
                end else begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d       = ST_IDLE;
                value_ready_d = 1'b1;
                exception_d   = flags_q.div_zero | flags_q.overflow;
                // A zero divisor skips the iterations, so quo_q still holds |A| and a_neg rebuilds A.
                if (flags_q.div_zero) begin
                    quotient_d  = DIV_ZERO_Q;
                    remainder_d = flags_q.a_neg ? -quo_q : quo_q;
                end else begin
                    quotient_d  = (flags_q.a_neg ^ flags_q.b_neg) ? -quo_q : quo_q;
                    remainder_d = flags_q.a_neg ? -rem_q : rem_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            divisor_q     <= '0;
            flags_q       <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            value_ready_q <= 1'b0;
            exception_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge value of the others.
            state_q       <= state_d;
            count_q       <= count_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            divisor_q     <= divisor_d;
            flags_q       <= flags_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            value_ready_q <= value_ready_d;
            exception_q   <= exception_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.value_ready = value_ready_q;
    assign bus.exception   = exception_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;

endmodule
